load_store_unit: RTL

Load/store unit between the MEM pipeline stage and `Data_memory`. It accepts one load or store request at a time over a valid/ready handshake and drives the data memory's word-wide, byte-addressed port. It performs RV32I sub-word extraction with sign or zero extension for loads. Sub-word stores use a read-modify-write sequence, because the memory always writes four bytes.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal funct3 for the direction, plus natural alignment of the access.
  function automatic logic req_legal(input logic       write,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (funct3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = ~addr_lo[0];
        F3_W:    ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = ~addr_lo[0];
        F3_W:        ok = (addr_lo == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational sub-word lane logic: load extraction with sign/zero extension
// and store merging of a byte or halfword into a full word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned Numbit = 32,
  parameter int unsigned Width  = 8
) (
  input  logic [Numbit-1:0] ld_word,
  input  logic [Numbit-1:0] st_word,
  input  logic [Numbit-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [Numbit-1:0] ld_data_c,
  output logic [Numbit-1:0] st_word_c
);

  localparam int unsigned Half = 2 * Width;

  logic [Width-1:0] byte_sel;
  logic [Half-1:0]  half_sel;

  always_comb begin
    byte_sel = ld_word[Width * 32'(addr_lo) +: Width];
    half_sel = ld_word[Half * 32'(addr_lo[1]) +: Half];
  end

  always_comb begin
    ld_data_c = '0;
    case (funct3)
      F3_B:    ld_data_c = {{(Numbit - Width){byte_sel[Width-1]}}, byte_sel};
      F3_BU:   ld_data_c = {{(Numbit - Width){1'b0}}, byte_sel};
      F3_H:    ld_data_c = {{(Numbit - Half){half_sel[Half-1]}}, half_sel};
      F3_HU:   ld_data_c = {{(Numbit - Half){1'b0}}, half_sel};
      F3_W:    ld_data_c = ld_word;
      default: ld_data_c = '0;
    endcase
  end

  // Only the addressed lane changes; the rest of the captured word is kept.
  always_comb begin
    st_word_c = st_word;
    case (funct3)
      F3_B:    st_word_c[Width * 32'(addr_lo) +: Width] = wdata[Width-1:0];
      F3_H:    st_word_c[Half * 32'(addr_lo[1]) +: Half] = wdata[Half-1:0];
      F3_W:    st_word_c = wdata;
      default: st_word_c = st_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-wide data memory; sub-word stores
// use read-modify-write. Define LSU_BOUNDS_CHECK_EN to reject out-of-range addresses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Numbit    = 32,
  parameter int unsigned Width     = 8,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [Numbit-1:0] req_addr,
  input  logic [Numbit-1:0] req_wdata,
  output logic              resp_valid,
  output logic [Numbit-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [Numbit-1:0] Address,
  output logic [Numbit-1:0] Write_data,
  input  logic [Numbit-1:0] Read_data
);

  localparam logic [Numbit-1:0] InRangeMask = Numbit'(MEM_BYTES - 1);
  localparam logic [Numbit-1:0] WordMask    = InRangeMask & ~Numbit'(3);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [Numbit-1:0] addr_q, addr_d;
  logic [Numbit-1:0] wdata_q, wdata_d;
  logic [Numbit-1:0] word_q, word_d;
  logic [Numbit-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              addr_oob_c;
  logic              req_ok_c;
  logic              mem_read_c;
  logic              mem_write_c;
  logic [Numbit-1:0] wr_data_c;
  logic [Numbit-1:0] ld_data_c;
  logic [Numbit-1:0] st_word_c;

`ifdef LSU_BOUNDS_CHECK_EN
  assign addr_oob_c = |(req_addr & ~InRangeMask);
`else
  assign addr_oob_c = 1'b0;
`endif

  assign req_ok_c = req_legal(req_write, req_funct3, req_addr[1:0]) & ~addr_oob_c;

  lsu_align #(
    .Numbit (Numbit),
    .Width  (Width)
  ) u_align (
    .ld_word   (Read_data),
    .st_word   (word_q),
    .wdata     (wdata_q),
    .addr_lo   (addr_q[1:0]),
    .funct3    (funct3_q),
    .ld_data_c (ld_data_c),
    .st_word_c (st_word_c)
  );

  // Next-state, capture and memory strobe decode.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    wr_data_c   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = ~req_ok_c;
          state_d  = req_ok_c ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        word_d = Read_data;
        if (write_q && (funct3_q == F3_W)) begin
          mem_write_c = 1'b1;
          wr_data_c   = wdata_q;
          state_d     = RESP;
        end else begin
          mem_read_c = 1'b1;
          if (write_q) begin
            state_d = MERGE_WR;
          end else begin
            rdata_d = ld_data_c;
            state_d = RESP;
          end
        end
      end
      MERGE_WR: begin
        mem_write_c = 1'b1;
        wr_data_c   = st_word_c;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset drops them at once.
  assign MemRead    = mem_read_c;
  assign MemWrite   = mem_write_c;
  assign Address    = (mem_read_c | mem_write_c) ? (addr_q & WordMask) : '0;
  assign Write_data = wr_data_c;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
